// File: rtl/decoder_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : decoder_mac_pipe                                           |
// | Description : Pipelined signed multiply-accumulate producing one shifted, |
// |               saturated dot-product result per last-tagged operand beat. |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module decoder_mac_pipe #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int dout_WIDTH = 16,
  parameter int NUM_STAGE  = 2,
  parameter int SHIFT      = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         sat
);

  localparam int c_prod_w = din0_WIDTH + din1_WIDTH;
  localparam logic signed [dout_WIDTH-1:0] c_dout_max = {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [dout_WIDTH-1:0] c_dout_min = {1'b1, {(dout_WIDTH-1){1'b0}}};

  logic                         w_adv;

  logic signed [din0_WIDTH-1:0] r_a;
  logic signed [din1_WIDTH-1:0] r_b;
  logic                         r_op_valid;
  logic                         r_op_last;
  logic signed [c_prod_w-1:0]   w_prod;

  logic signed [c_prod_w-1:0]   r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]         r_pv;
  logic [NUM_STAGE-1:0]         r_pl;

  logic signed [c_prod_w-1:0]   w_tail;
  logic                         w_tail_v;
  logic                         w_tail_l;
  logic                         w_load;

  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic [ACC_WIDTH-dout_WIDTH:0] w_hi;
  logic                         w_ovf;
  logic signed [dout_WIDTH-1:0] w_dout_next;

  logic                         r_out_valid;
  logic signed [dout_WIDTH-1:0] r_dout;
  logic                         r_sat;

  // A held result blocks the whole datapath; ce=0 freezes everything.
  assign w_adv    = ce & ~(r_out_valid & ~out_ready);
  assign in_ready = w_adv;

  // Operand capture register ahead of the multiplier pipeline.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op_valid <= 1'b0;
      r_op_last  <= 1'b0;
    end else if (w_adv) begin
      r_a        <= din0;
      r_b        <= din1;
      r_op_valid <= in_valid;
      r_op_last  <= in_valid & in_last;
    end
  end

  assign w_prod = r_a * r_b;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_prod[i] <= '0;
      end
      r_pv <= '0;
      r_pl <= '0;
    end else if (w_adv) begin
      r_prod[0] <= w_prod;
      r_pv[0]   <= r_op_valid;
      r_pl[0]   <= r_op_last;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_prod[i] <= r_prod[i-1];
        r_pv[i]   <= r_pv[i-1];
        r_pl[i]   <= r_pl[i-1];
      end
    end
  end

  assign w_tail   = r_prod[NUM_STAGE-1];
  assign w_tail_v = r_pv[NUM_STAGE-1];
  assign w_tail_l = r_pl[NUM_STAGE-1];
  assign w_load   = w_tail_v & w_tail_l;

  assign w_ext   = ACC_WIDTH'(w_tail);
  assign w_sum   = r_acc + w_ext;
  assign w_shift = w_sum >>> SHIFT;

  // Fits in dout only if every bit from the dout sign bit upward agrees.
  assign w_hi        = w_shift[ACC_WIDTH-1:dout_WIDTH-1];
  assign w_ovf       = ~((&w_hi) | ~(|w_hi));
  assign w_dout_next = w_ovf ? (w_shift[ACC_WIDTH-1] ? c_dout_min : c_dout_max)
                             : w_shift[dout_WIDTH-1:0];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_acc <= '0;
    end else if (w_adv && w_tail_v) begin
      r_acc <= w_tail_l ? '0 : w_sum;
    end
  end

  // Under w_adv any held result is either absent or being consumed.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_sat       <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_dout <= w_dout_next;
        r_sat  <= w_ovf;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_decoder_mac_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_decoder_mac_pipe                                        |
// | Description : Scoreboard bench for decoder_mac_pipe with random stimulus.|
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_decoder_mac_pipe;

  localparam int W0 = 16;
  localparam int W1 = 10;
  localparam int WA = 32;
  localparam int WO = 16;
  localparam int NS = 2;
  localparam int SH = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          ce;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic signed [W0-1:0] din0;
  logic signed [W1-1:0] din1;
  logic          out_valid;
  logic          out_ready;
  logic signed [WO-1:0] dout;
  logic          sat;

  typedef struct {
    int val;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_acc = 0;
  int   cycle     = 0;
  bit   rand_mode = 1'b0;

  always #5 ap_clk = ~ap_clk;

  decoder_mac_pipe #(
    .din0_WIDTH(W0),
    .din1_WIDTH(W1),
    .ACC_WIDTH (WA),
    .dout_WIDTH(WO),
    .NUM_STAGE (NS),
    .SHIFT     (SH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .ce       (ce),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .sat      (sat)
  );

  always @(posedge ap_clk) cycle <= cycle + 1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Reference: dot product in plain integer arithmetic, floor shift, clamp.
  function automatic void model_beat(input int a, input int b, input bit last);
    int   p;
    int   s;
    int   sh;
    int   hi;
    int   lo;
    exp_t e;
    p  = a * b;
    hi = (1 <<< (WO - 1)) - 1;
    lo = -(1 <<< (WO - 1));
    if (last) begin
      s  = model_acc + p;
      sh = s >>> SH;
      if (sh > hi) begin
        e.val = hi;
        e.sat = 1'b1;
      end else if (sh < lo) begin
        e.val = lo;
        e.sat = 1'b1;
      end else begin
        e.val = sh;
        e.sat = 1'b0;
      end
      exp_q.push_back(e);
      model_acc = 0;
    end else begin
      model_acc = model_acc + p;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input int a, input int b, input bit last);
    int waits;
    waits    = 0;
    din0     = W0'(a);
    din1     = W1'(b);
    in_valid = 1'b1;
    in_last  = last;
    @(negedge ap_clk);
    while (!in_ready) begin
      waits++;
      if (waits > 1000) begin
        errors++;
        $display("FAIL beat_accept_timeout actual=%0d waits required=accept", waits);
        $fatal(1, "beat never accepted");
      end
      @(posedge ap_clk);
      #1;
      @(negedge ap_clk);
    end
    model_beat(a, b, last);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 300) begin
      @(posedge ap_clk);
      #1;
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: compares the presented result against the queue head.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst) begin
        check("in_ready", int'(in_ready), int'(ce && !(out_valid && !out_ready)));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0d required=none", int'(dout));
          end else begin
            check("dout", int'(dout), exp_q[0].val);
            check("sat", int'(sat), int'(exp_q[0].sat));
            if (out_ready && ce) begin
              void'(exp_q.pop_front());
              pop_cyc.push_back(cycle);
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (rand_mode) begin
        ce        = ($urandom_range(0, 9) != 0);
        out_ready = ($urandom_range(0, 9) < 7);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int k;
    int len;
    int a;
    int b;
    ap_rst    = 1'b1;
    ce        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    din0      = '0;
    din1      = '0;
    @(posedge ap_clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_sat", int'(sat), 0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // Latency of a single last beat
    send_beat(256, 3, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    check("latency", lat, NS + 1);
    drain();

    send_beat(-1, 1, 1'b1);
    drain();

    for (int i = 0; i < 4; i++) send_beat(32767, 511, i == 3);
    send_beat(-32768, 511, 1'b1);
    drain();

    // Back-to-back vectors
    send_beat(256, 1, 1'b0);
    send_beat(256, 1, 1'b1);
    send_beat(512, 1, 1'b1);
    drain();
    if (pop_cyc.size() >= 2)
      check("b2b_gap", pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2], 1);
    else
      check("b2b_results", pop_cyc.size(), 2);

    // Backpressure held for five cycles while beats keep arriving
    out_ready = 1'b0;
    fork
      begin
        send_beat(300, 2, 1'b0);
        send_beat(300, 2, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(-500, 100, 1'b0);
        send_beat(7, 7, 1'b1);
      end
      begin
        k = 0;
        while (!out_valid && k < 50) begin
          @(negedge ap_clk);
          k++;
        end
        repeat (5) @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with a partial vector in flight and a result held
    out_ready = 1'b0;
    send_beat(256, 3, 1'b1);
    send_beat(100, 2, 1'b0);
    send_beat(100, 2, 1'b0);
    #2;
    ap_rst = 1'b1;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_dout", int'(dout), 0);
    check("arst_sat", int'(sat), 0);
    exp_q.delete();
    model_acc = 0;
    #3;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    send_beat(256, 4, 1'b1);
    drain();

    // Randomized vectors with bubbles, stalls and clock-enable gaps
    rand_mode = 1'b1;
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0)
          a = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
        else
          a = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 7) == 0)
          b = ($urandom_range(0, 1) != 0) ? 511 : -512;
        else
          b = int'($urandom_range(0, 1023)) - 512;
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(posedge ap_clk);
          #1;
        end
        send_beat(a, b, j == len - 1);
      end
    end
    rand_mode = 1'b0;
    ce        = 1'b1;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
